hx8352_bus_writer: RTL

// Write-only 8080 bus engine for the HX8352 LCD. It sits downstream of the init/pixel sequencers.
// It buffers {rs, data} words in a FIFO and drives lcd_cs/lcd_rs/lcd_wr/data_output with programmable setup/strobe timing.

---
 rtl/hx8352_bus_writer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/hx8352_bus_writer.sv
// FIFO-buffered write-only 8080 bus engine for the HX8352 LCD.
// Ports: in_* valid/ready push, lcd_*/data_output bus, busy/fifo_level.
module hx8352_bus_writer #(
  parameter int DEPTH       = 16,
  parameter int SETUP_CYC   = 1,
  parameter int WR_LOW_CYC  = 2,
  parameter int WR_HIGH_CYC = 2,
  parameter int CS_IDLE_CYC = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_rs,
  input  logic [15:0]            in_data,
  output logic [15:0]            data_output,
  output logic                   lcd_rs,
  output logic                   lcd_wr,
  output logic                   lcd_rd,
  output logic                   lcd_cs,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WR_LOW,
    WR_HIGH,
    CS_HOLD
  } state_t;

  typedef struct packed {
    logic        rs;
    logic [15:0] data;
  } word_t;

  word_t         mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [LW-1:0] level;
  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic          push;
  logic          pop;
  logic          empty;
  logic          full;
  logic          done;

  assign empty      = (level == '0);
  assign full       = (level == LW'(DEPTH));
  assign in_ready   = !full && rst;
  assign push       = in_valid && in_ready;
  assign done       = (cnt == '0);
  assign busy       = !empty || (state != IDLE);
  assign fifo_level = level;
  assign lcd_rd     = 1'b1;

  // storage needs no reset; push is already gated by rst
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= '{rs: in_rs, data: in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // each state loads cnt with its length-1 and leaves when it hits 0
  always_comb begin
    state_n = state;
    cnt_n   = done ? cnt : cnt - CW'(1);
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = SETUP;
          cnt_n   = CW'(SETUP_CYC - 1);
        end
      end
      SETUP: begin
        if (done) begin
          state_n = WR_LOW;
          cnt_n   = CW'(WR_LOW_CYC - 1);
        end
      end
      WR_LOW: begin
        if (done) begin
          state_n = WR_HIGH;
          cnt_n   = CW'(WR_HIGH_CYC - 1);
        end
      end
      WR_HIGH: begin
        if (done) begin
          if (!empty) begin
            pop     = 1'b1;
            state_n = SETUP;
            cnt_n   = CW'(SETUP_CYC - 1);
          end else begin
            state_n = CS_HOLD;
            cnt_n   = CW'(CS_IDLE_CYC - 1);
          end
        end
      end
      CS_HOLD: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = SETUP;
          cnt_n   = CW'(SETUP_CYC - 1);
        end else if (done) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // bus pins are registered from the next state so they move
  // on the same edge as the state change
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      lcd_cs      <= 1'b1;
      lcd_wr      <= 1'b1;
      lcd_rs      <= 1'b0;
      data_output <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      lcd_cs <= (state_n == IDLE);
      lcd_wr <= (state_n != WR_LOW);
      if (pop) begin
        data_output <= mem[rptr].data;
        lcd_rs      <= mem[rptr].rs;
      end
    end
  end

endmodule
